// File: rtl/tlb_mport_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlb_mport_pkg
// Description : Shared TLB entry, exception and CP0-op types for tlb_mport.
// Revision    : 1.0 - initial release
// ============================================================================
package tlb_mport_pkg;

    localparam int TLB_ENTRIES = 16;
    localparam int TLB_ASID_W  = 8;

    typedef struct packed {
        logic [18:0]           vpn2;
        logic [TLB_ASID_W-1:0] asid;
        logic                  g;
        logic [19:0]           pfn0;
        logic [2:0]            c0;
        logic                  d0;
        logic                  v0;
        logic [19:0]           pfn1;
        logic [2:0]            c1;
        logic                  d1;
        logic                  v1;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'd0,
        EXC_REFILL   = 2'd1,
        EXC_INVALID  = 2'd2,
        EXC_MODIFIED = 2'd3
    } tlb_exc_t;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_WI  = 3'd1,
        OP_WR  = 3'd2,
        OP_P   = 3'd3,
        OP_R   = 3'd4
    } tlb_op_t;

endpackage
`default_nettype wire

// File: rtl/tlb_mport_match.sv
`default_nettype none
// ============================================================================
// Module      : tlb_match
// Description : Combinational VPN2/ASID match, lowest matching index wins.
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_match
    import tlb_mport_pkg::*;
#(
    parameter int N_ENTRIES = TLB_ENTRIES,
    parameter int ASID_W    = TLB_ASID_W,
    localparam int IDX_W    = $clog2(N_ENTRIES)
) (
    input  logic [N_ENTRIES-1:0][18:0]       vpn2_tab,
    input  logic [N_ENTRIES-1:0][ASID_W-1:0] asid_tab,
    input  logic [N_ENTRIES-1:0]             g_tab,
    input  logic [18:0]                      vpn2,
    input  logic [ASID_W-1:0]                asid,
    output logic                             hit,
    output logic [IDX_W-1:0]                 idx
);

    // Scan from the top down so the last (lowest) match is the one kept.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if ((vpn2_tab[i] == vpn2) && (g_tab[i] || (asid_tab[i] == asid))) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tlb_mport.sv
`default_nettype none
// ============================================================================
// Module      : tlb_mport
// Description : Multi-port registered joint TLB with TLBWI/WR/P/R and Random.
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_mport
    import tlb_mport_pkg::*;
#(
    parameter int N_ENTRIES = TLB_ENTRIES,
    parameter int N_PORTS   = 2,
    parameter int ASID_W    = TLB_ASID_W,
    localparam int IDX_W    = $clog2(N_ENTRIES)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [N_PORTS-1:0]      lk_valid,
    input  logic [N_PORTS-1:0][31:0] lk_vaddr,
    input  logic [N_PORTS-1:0]      lk_store,
    input  logic [ASID_W-1:0]       asid,
    output logic [N_PORTS-1:0]      rs_valid,
    output logic [N_PORTS-1:0][31:0] rs_paddr,
    output logic [N_PORTS-1:0][1:0] rs_exc,
    input  tlb_op_t                 op,
    input  logic [IDX_W-1:0]        op_index,
    input  tlb_entry_t              op_entry,
    input  logic [IDX_W-1:0]        wired,
    input  logic                    wired_we,
    output logic                    op_done,
    output logic [31:0]             p_index,
    output tlb_entry_t              r_entry,
    output logic [IDX_W-1:0]        random
);

    localparam logic [IDX_W-1:0] c_RAND_MAX = IDX_W'(N_ENTRIES - 1);

    tlb_entry_t [N_ENTRIES-1:0]       r_tab;
    logic [N_ENTRIES-1:0][18:0]       w_vpn2_tab;
    logic [N_ENTRIES-1:0][ASID_W-1:0] w_asid_tab;
    logic [N_ENTRIES-1:0]             w_g_tab;
    logic [IDX_W-1:0]                 r_random;
    logic [IDX_W-1:0]                 w_random_nxt;
    logic                             r_op_done;
    logic [31:0]                      r_p_index;
    tlb_entry_t                       r_rd_entry;
    logic                             w_p_hit;
    logic [IDX_W-1:0]                 w_p_idx;

    always_comb begin
        for (int i = 0; i < N_ENTRIES; i++) begin
            w_vpn2_tab[i] = r_tab[i].vpn2;
            w_asid_tab[i] = r_tab[i].asid;
            w_g_tab[i]    = r_tab[i].g;
        end
    end

    generate
        for (genvar p = 0; p < N_PORTS; p++) begin : g_port
            logic             w_hit;
            logic [IDX_W-1:0] w_idx;
            logic             w_v;
            logic             w_d;
            logic [19:0]      w_pfn;
            logic [31:0]      w_paddr;
            logic [1:0]       w_exc;
            logic             r_valid;
            logic [31:0]      r_paddr;
            logic [1:0]       r_exc;

            tlb_match #(
                .N_ENTRIES(N_ENTRIES),
                .ASID_W   (ASID_W)
            ) u_match (
                .vpn2_tab(w_vpn2_tab),
                .asid_tab(w_asid_tab),
                .g_tab   (w_g_tab),
                .vpn2    (lk_vaddr[p][31:13]),
                .asid    (asid),
                .hit     (w_hit),
                .idx     (w_idx)
            );

            always_comb begin
                w_pfn = lk_vaddr[p][12] ? r_tab[w_idx].pfn1 : r_tab[w_idx].pfn0;
                w_v   = lk_vaddr[p][12] ? r_tab[w_idx].v1   : r_tab[w_idx].v0;
                w_d   = lk_vaddr[p][12] ? r_tab[w_idx].d1   : r_tab[w_idx].d0;
                if (lk_vaddr[p][31:30] == 2'b10) begin
                    w_paddr = {3'b000, lk_vaddr[p][28:0]};
                    w_exc   = EXC_NONE;
                end else begin
                    w_paddr = {w_pfn, lk_vaddr[p][11:0]};
                    if (!w_hit)
                        w_exc = EXC_REFILL;
                    else if (!w_v)
                        w_exc = EXC_INVALID;
                    else if (lk_store[p] && !w_d)
                        w_exc = EXC_MODIFIED;
                    else
                        w_exc = EXC_NONE;
                end
            end

            // Address/exception only load on a request so idle outputs stay stable.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_valid <= 1'b0;
                    r_paddr <= '0;
                    r_exc   <= EXC_NONE;
                end else begin
                    r_valid <= lk_valid[p];
                    if (lk_valid[p]) begin
                        r_paddr <= w_paddr;
                        r_exc   <= w_exc;
                    end
                end
            end

            assign rs_valid[p] = r_valid;
            assign rs_paddr[p] = r_paddr;
            assign rs_exc[p]   = r_exc;
        end
    endgenerate

    tlb_match #(
        .N_ENTRIES(N_ENTRIES),
        .ASID_W   (ASID_W)
    ) u_probe (
        .vpn2_tab(w_vpn2_tab),
        .asid_tab(w_asid_tab),
        .g_tab   (w_g_tab),
        .vpn2    (op_entry.vpn2),
        .asid    (op_entry.asid),
        .hit     (w_p_hit),
        .idx     (w_p_idx)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_tab <= '0;
        else if (op == OP_WI)
            r_tab[op_index] <= op_entry;
        else if (op == OP_WR)
            r_tab[r_random] <= op_entry;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_op_done  <= 1'b0;
            r_p_index  <= '0;
            r_rd_entry <= '0;
        end else begin
            r_op_done <= (op == OP_P) || (op == OP_R);
            if (op == OP_P)
                r_p_index <= w_p_hit ? 32'(w_p_idx) : 32'h8000_0000;
            if (op == OP_R)
                r_rd_entry <= r_tab[op_index];
        end
    end

    // Random wraps back to the top when it reaches Wired; a Wired write restarts it.
    always_comb begin
        if (wired_we || (wired >= c_RAND_MAX) || (r_random == wired))
            w_random_nxt = c_RAND_MAX;
        else
            w_random_nxt = r_random - 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_random <= c_RAND_MAX;
        else
            r_random <= w_random_nxt;
    end

    assign op_done = r_op_done;
    assign p_index = r_p_index;
    assign r_entry = r_rd_entry;
    assign random  = r_random;

endmodule
`default_nettype wire

// File: tb/tb_tlb_mport.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_tlb_mport
// Description : Directed scoreboard bench for tlb_mport (16 entries, 2 ports).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlb_mport;
    import tlb_mport_pkg::*;

    localparam int NE = 16;
    localparam int NP = 2;
    localparam int AW = 8;
    localparam int IW = 4;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic [NP-1:0]        lk_valid;
    logic [NP-1:0][31:0]  lk_vaddr;
    logic [NP-1:0]        lk_store;
    logic [AW-1:0]        asid;
    logic [NP-1:0]        rs_valid;
    logic [NP-1:0][31:0]  rs_paddr;
    logic [NP-1:0][1:0]   rs_exc;
    tlb_op_t              op;
    logic [IW-1:0]        op_index;
    tlb_entry_t           op_entry;
    logic [IW-1:0]        wired;
    logic                 wired_we;
    logic                 op_done;
    logic [31:0]          p_index;
    tlb_entry_t           r_entry;
    logic [IW-1:0]        random;

    tlb_mport #(.N_ENTRIES(NE), .N_PORTS(NP), .ASID_W(AW)) dut (
        .clk(clk), .resetn(resetn),
        .lk_valid(lk_valid), .lk_vaddr(lk_vaddr), .lk_store(lk_store), .asid(asid),
        .rs_valid(rs_valid), .rs_paddr(rs_paddr), .rs_exc(rs_exc),
        .op(op), .op_index(op_index), .op_entry(op_entry),
        .wired(wired), .wired_we(wired_we),
        .op_done(op_done), .p_index(p_index), .r_entry(r_entry), .random(random)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] paddr;
        logic [1:0]  exc;
        bit          chk_pa;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    tlb_entry_t e3, ew;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic tlb_entry_t mk(input logic [18:0] vpn2, input logic [7:0] a, input logic g,
                                      input logic [19:0] pfn0, input logic v0, input logic d0,
                                      input logic [19:0] pfn1, input logic v1, input logic d1);
        tlb_entry_t e;
        e      = '0;
        e.vpn2 = vpn2; e.asid = a; e.g = g;
        e.pfn0 = pfn0; e.v0 = v0; e.d0 = d0;
        e.pfn1 = pfn1; e.v1 = v1; e.d1 = d1;
        return e;
    endfunction

    task automatic lookup(input int p, input logic [31:0] va, input logic st,
                          input logic [31:0] pa, input logic [1:0] ex, input bit cp);
        lk_valid[p] = 1'b1;
        lk_vaddr[p] = va;
        lk_store[p] = st;
        sb.push_back('{p, pa, ex, cp});
    endtask

    // Every response must appear exactly one edge after its request.
    task automatic check_rs();
        for (int p = 0; p < NP; p++) begin
            int k;
            k = -1;
            foreach (sb[i]) if (k < 0 && sb[i].port == p) k = i;
            chk($sformatf("rs_valid%0d", p), 128'(rs_valid[p]), 128'(k >= 0));
            if (k >= 0) begin
                if (rs_valid[p]) begin
                    chk($sformatf("rs_exc%0d", p), 128'(rs_exc[p]), 128'(sb[k].exc));
                    if (sb[k].chk_pa)
                        chk($sformatf("rs_paddr%0d", p), 128'(rs_paddr[p]), 128'(sb[k].paddr));
                end
                sb.delete(k);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        lk_valid = '0;
        op       = OP_NOP;
        wired_we = 1'b0;
        check_rs();
    endtask

    initial begin
        resetn = 1'b0; lk_valid = '0; lk_vaddr = '0; lk_store = '0; asid = '0;
        op = OP_NOP; op_index = '0; op_entry = '0; wired = '0; wired_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rs_valid", 128'(rs_valid), 128'(0));
        chk("rst_rs_paddr", 128'(rs_paddr), 128'(0));
        chk("rst_rs_exc", 128'(rs_exc), 128'(0));
        chk("rst_op_done", 128'(op_done), 128'(0));
        chk("rst_p_index", 128'(p_index), 128'(0));
        chk("rst_r_entry", 128'(r_entry), 128'(0));
        chk("rst_random", 128'(random), 128'(15));
        resetn = 1'b1;

        // Unmapped kseg0/kseg1 on both ports
        lookup(0, 32'h8000_1234, 1'b0, 32'h0000_1234, EXC_NONE, 1);
        lookup(1, 32'hA000_0010, 1'b1, 32'h0000_0010, EXC_NONE, 1);
        step();

        // WI index 3 with a same-cycle lookup that must still miss
        e3 = mk(19'h200, 8'd5, 1'b0, 20'h0, 1'b0, 1'b0, 20'h12, 1'b1, 1'b0);
        op = OP_WI; op_index = 4'd3; op_entry = e3; asid = 8'd5;
        lookup(0, 32'h0040_1ABC, 1'b0, 32'h0, EXC_REFILL, 0);
        step();
        lookup(0, 32'h0040_1ABC, 1'b0, 32'h0001_2ABC, EXC_NONE, 1);
        lookup(1, 32'h0040_1ABC, 1'b1, 32'h0, EXC_MODIFIED, 0);
        step();
        lookup(0, 32'h0040_0ABC, 1'b0, 32'h0, EXC_INVALID, 0);
        lookup(1, 32'h8000_0040, 1'b0, 32'h0000_0040, EXC_NONE, 1);
        step();
        asid = 8'd6;
        lookup(0, 32'h0040_1ABC, 1'b0, 32'h0, EXC_REFILL, 0);
        step();
        asid = 8'd5;

        // Duplicate match in entries 7 and 2: lowest index wins
        op = OP_WI; op_index = 4'd7; op_entry = mk(19'h300, 8'd1, 1'b1, 20'h77, 1'b1, 1'b1, 20'h0, 1'b0, 1'b0);
        step();
        op = OP_WI; op_index = 4'd2; op_entry = mk(19'h300, 8'd2, 1'b1, 20'h22, 1'b1, 1'b1, 20'h0, 1'b0, 1'b0);
        step();
        asid = 8'd9;
        lookup(1, 32'h0060_0100, 1'b1, 32'h0002_2100, EXC_NONE, 1);
        op = OP_P; op_entry = mk(19'h300, 8'd3, 1'b0, 20'h0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0);
        step();
        chk("p_done", 128'(op_done), 128'(1));
        chk("p_index_dup", 128'(p_index), 128'(2));
        op = OP_P; op_entry = mk(19'h1234, 8'd3, 1'b0, 20'h0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0);
        step();
        chk("p_index_miss", 128'(p_index), 128'h8000_0000);
        op = OP_R; op_index = 4'd3;
        step();
        chk("r_done", 128'(op_done), 128'(1));
        chk("r_entry3", 128'(r_entry), 128'(e3));
        step();
        chk("nop_done", 128'(op_done), 128'(0));

        // Random with Wired = 4, and TLBWR using the op-cycle Random
        wired = 4'd4; wired_we = 1'b1;
        step();
        chk("rand_wired_we", 128'(random), 128'(15));
        ew = mk(19'h500, 8'd0, 1'b1, 20'h0, 1'b0, 1'b0, 20'h55, 1'b1, 1'b1);
        op = OP_WR; op_entry = ew;
        step();
        chk("rand_after_wr", 128'(random), 128'(14));
        for (int v = 13; v >= 4; v--) begin
            step();
            chk($sformatf("rand_%0d", v), 128'(random), 128'(v));
        end
        step();
        chk("rand_wrap", 128'(random), 128'(15));
        step();
        chk("rand_wrap_14", 128'(random), 128'(14));
        wired_we = 1'b1;
        step();
        chk("rand_we_mid", 128'(random), 128'(15));
        op = OP_R; op_index = 4'd15;
        lookup(0, 32'h00A0_1000, 1'b1, 32'h0005_5000, EXC_NONE, 1);
        step();
        chk("r_entry_wr", 128'(r_entry), 128'(ew));
        wired = 4'd15;
        step();
        chk("rand_hold_a", 128'(random), 128'(15));
        step();
        chk("rand_hold_b", 128'(random), 128'(15));

        // Reset lands between request and response
        lk_valid[0] = 1'b1; lk_vaddr[0] = 32'h0040_1ABC; lk_store[0] = 1'b0;
        #3 resetn = 1'b0;
        #1 chk("rst_async_valid", 128'(rs_valid), 128'(0));
        @(posedge clk);
        #1;
        chk("rst_hold_valid", 128'(rs_valid), 128'(0));
        chk("rst_hold_random", 128'(random), 128'(15));
        lk_valid = '0;
        resetn = 1'b1;
        wired = 4'd0;
        step();
        asid = 8'd5;
        lookup(0, 32'h0040_1ABC, 1'b0, 32'h0, EXC_REFILL, 0);
        op = OP_P; op_entry = e3;
        step();
        chk("p_after_rst", 128'(p_index), 128'h8000_0000);
        chk("sb_drained", 128'(sb.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
